// File: rtl/pcie_cmd_packetizer.sv
// Host-side command packetizer: turns one descriptor plus optional payload into the
// 4-word header + payload stream for the card receiver, then optionally awaits a response.
module pcie_cmd_packetizer #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 32
) (
  input  logic             pcie_clk,
  input  logic             pcie_rst,
  input  logic             desc_valid,
  output logic             desc_ready,
  input  logic [7:0]       desc_opcode,
  input  logic [23:0]      desc_tag,
  input  logic [31:0]      desc_addr,
  input  logic [CNT_W-1:0] desc_length,
  input  logic [31:0]      desc_param1,
  input  logic [31:0]      pl_data,
  input  logic             pl_valid,
  output logic             pl_ready,
  output logic [31:0]      tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [31:0]      rsp_data,
  input  logic             rsp_valid,
  output logic [31:0]      rsp_word,
  output logic             busy,
  output logic             cmd_done,
  output logic [1:0]       cmd_status
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [7:0] OP_LOAD_MODEL = 8'h01;
  localparam logic [7:0] OP_LOAD_INPUT = 8'h02;
  localparam logic [7:0] OP_DMA        = 8'h05;
  localparam logic [7:0] OP_MAX        = 8'h06;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_BAD_OP  = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, WAIT_RSP, DONE} state_t;

  state_t           state_q;
  logic [7:0]       opcode_q;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] length_q;
  logic [31:0]      param1_q;
  logic [1:0]       hdrIdx_q;
  logic [CNT_W-1:0] plCnt_q;
  logic [TO_W-1:0]  toCnt_q;
  logic [31:0]      txData_q;
  logic             txValid_q;
  logic [31:0]      rspWord_q;
  logic             cmdDone_q;
  logic [1:0]       cmdStatus_q;

  logic        txFire;
  logic        descFire;
  logic        plFire;
  logic        opValid;
  logic        isLoad;
  logic        lenNonZero;
  logic        plEarly;
  logic        plRun;
  logic [31:0] nextHdr_d;

  assign txFire     = txValid_q && tx_ready;
  assign opValid    = (desc_opcode != 8'h00) && (desc_opcode <= OP_MAX);
  assign isLoad     = (opcode_q == OP_LOAD_MODEL) || (opcode_q == OP_LOAD_INPUT);
  assign lenNonZero = (length_q != '0);

  // The first payload word is pulled while word3 leaves so header and payload run back to back.
  assign plEarly = (state_q == HDR) && (hdrIdx_q == 2'd3) && isLoad && lenNonZero && tx_ready;
  assign plRun   = (state_q == PAYLOAD) && (plCnt_q < length_q) && (!txValid_q || tx_ready);

  assign desc_ready = !pcie_rst && (state_q == IDLE);
  assign pl_ready   = !pcie_rst && (plEarly || plRun);
  assign descFire   = desc_valid && desc_ready;
  assign plFire     = pl_valid && pl_ready;

  always_comb begin
    nextHdr_d = param1_q;
    case (hdrIdx_q)
      2'd0:    nextHdr_d = addr_q;
      2'd1:    nextHdr_d = 32'(length_q);
      default: nextHdr_d = param1_q;
    endcase
  end

  always_ff @(posedge pcie_clk) begin
    if (pcie_rst) begin
      state_q     <= IDLE;
      opcode_q    <= '0;
      addr_q      <= '0;
      length_q    <= '0;
      param1_q    <= '0;
      hdrIdx_q    <= '0;
      plCnt_q     <= '0;
      toCnt_q     <= '0;
      txData_q    <= '0;
      txValid_q   <= 1'b0;
      rspWord_q   <= '0;
      cmdDone_q   <= 1'b0;
      cmdStatus_q <= ST_OK;
    end else begin
      cmdDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (descFire) begin
            opcode_q <= desc_opcode;
            addr_q   <= desc_addr;
            length_q <= desc_length;
            param1_q <= desc_param1;
            hdrIdx_q <= '0;
            plCnt_q  <= '0;
            toCnt_q  <= '0;
            if (opValid) begin
              txData_q  <= {desc_opcode, desc_tag};
              txValid_q <= 1'b1;
              state_q   <= HDR;
            end else begin
              cmdDone_q   <= 1'b1;
              cmdStatus_q <= ST_BAD_OP;
              state_q     <= DONE;
            end
          end
        end

        HDR: begin
          if (txFire) begin
            if (hdrIdx_q != 2'd3) begin
              hdrIdx_q <= hdrIdx_q + 2'd1;
              txData_q <= nextHdr_d;
            end else if (isLoad && lenNonZero) begin
              state_q <= PAYLOAD;
              if (plFire) begin
                txData_q <= pl_data;
                plCnt_q  <= CNT_W'(1);
              end else begin
                txValid_q <= 1'b0;
              end
            end else if (isLoad || (opcode_q == OP_DMA)) begin
              txValid_q   <= 1'b0;
              cmdDone_q   <= 1'b1;
              cmdStatus_q <= ST_OK;
              state_q     <= DONE;
            end else begin
              txValid_q <= 1'b0;
              toCnt_q   <= '0;
              state_q   <= WAIT_RSP;
            end
          end
        end

        PAYLOAD: begin
          if (!txValid_q || tx_ready) begin
            if (plFire) begin
              txData_q  <= pl_data;
              txValid_q <= 1'b1;
              plCnt_q   <= plCnt_q + CNT_W'(1);
            end else begin
              txValid_q <= 1'b0;
              if (plCnt_q == length_q) begin
                cmdDone_q   <= 1'b1;
                cmdStatus_q <= ST_OK;
                state_q     <= DONE;
              end
            end
          end
        end

        // A response arriving on the terminal count still wins over the timeout.
        WAIT_RSP: begin
          if (rsp_valid) begin
            rspWord_q   <= rsp_data;
            cmdDone_q   <= 1'b1;
            cmdStatus_q <= ST_OK;
            state_q     <= DONE;
          end else if (toCnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            cmdDone_q   <= 1'b1;
            cmdStatus_q <= ST_TIMEOUT;
            state_q     <= DONE;
          end else begin
            toCnt_q <= toCnt_q + TO_W'(1);
          end
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_data    = txData_q;
  assign tx_valid   = txValid_q;
  assign rsp_word   = rspWord_q;
  assign busy       = (state_q != IDLE);
  assign cmd_done   = cmdDone_q;
  assign cmd_status = cmdStatus_q;

endmodule
